// File: rtl/fpf_pkg.sv
// Shared constants and bit-layout helpers for the flattened-priority request stage.
// Aging logic in the top is enabled by defining FPF_AGING_EN.
package fpf_pkg;

    localparam int FPF_N         = 24;
    localparam int FPF_P         = 8;
    localparam int FPF_AGE_W     = 4;
    localparam int FPF_AGE_LIMIT = 12;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    // Priority vector is requester-major.
    function automatic int prio_idx(input int i, input int j, input int p);
        return i * p + j;
    endfunction

    // Permit vector is level-major.
    function automatic int permit_idx(input int i, input int j, input int n);
        return j * n + i;
    endfunction

endpackage

// File: rtl/fpf_prio_encode.sv
// Highest-set-bit encoder: P-bit match vector to level index plus hit flag.
module fpf_prio_encode #(
    parameter int P     = 8,
    parameter int LVL_W = 3
) (
    input  logic [P-1:0]     vec_i,
    output logic [LVL_W-1:0] lvl_o,
    output logic             hit_o
);

    always_comb begin
        lvl_o = '0;
        hit_o = |vec_i;
        for (int j = 0; j < P; j++) begin
            if (vec_i[j]) lvl_o = LVL_W'(j);
        end
    end

endmodule

// File: rtl/fpf_request_stage.sv
// Registered flattened-priority request evaluator with valid/ready output.
// Define FPF_AGING_EN to enable grant-feedback starvation promotion.
module fpf_request_stage
    import fpf_pkg::*;
#(
    parameter int N         = FPF_N,
    parameter int P         = FPF_P,
    parameter int AGE_W     = FPF_AGE_W,
    parameter int AGE_LIMIT = FPF_AGE_LIMIT,
    localparam int LVL_W    = clog2_min1(P)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [N*P-1:0]     i_priority,
    input  logic [N*P-1:0]     i_p_r,
    input  logic               i_grant_valid,
    input  logic [N-1:0]       i_grant,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [N-1:0]       o_request,
    output logic [N*LVL_W-1:0] o_level,
    output logic               o_any
);

    localparam logic [LVL_W-1:0] TOP_LVL = LVL_W'(P - 1);
    localparam logic [AGE_W-1:0] LIMIT   = AGE_W'(AGE_LIMIT);

    logic               valid_q;
    logic [N-1:0]       req_q, req_d;
    logic [N*LVL_W-1:0] lvl_q, lvl_d;
    logic               load;
    logic               accept;

    assign o_ready = !valid_q || i_ready;
    assign load    = i_valid && o_ready;
    assign accept  = valid_q && i_ready;

`ifdef FPF_AGING_EN
    // Request pattern of the beat most recently taken downstream.
    logic [N-1:0] fb_req_q;
    logic         seen_q;
    logic         fb_upd;

    assign fb_upd = i_grant_valid && seen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_req_q <= '0;
            seen_q   <= 1'b0;
        end else if (accept) begin
            fb_req_q <= req_q;
            seen_q   <= 1'b1;
        end
    end
`else
    logic unused_fb;
    assign unused_fb = ^{i_grant_valid, i_grant, accept, LIMIT};
`endif

    for (genvar i = 0; i < N; i++) begin : g_req
        logic [P-1:0]     match;
        logic [LVL_W-1:0] raw_lvl;
        logic             promote;

        for (genvar j = 0; j < P; j++) begin : g_lvl
            assign match[j] = i_priority[prio_idx(i, j, P)]
                            & i_p_r[permit_idx(i, j, N)];
        end

        fpf_prio_encode #(
            .P     (P),
            .LVL_W (LVL_W)
        ) u_enc (
            .vec_i (match),
            .lvl_o (raw_lvl),
            .hit_o (req_d[i])
        );

`ifdef FPF_AGING_EN
        logic [AGE_W-1:0] age_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                age_q <= '0;
            end else if (fb_upd) begin
                if (fb_req_q[i] && !i_grant[i])
                    age_q <= (age_q == LIMIT) ? age_q : age_q + AGE_W'(1);
                else
                    age_q <= '0;
            end
        end

        assign promote = req_d[i] && (age_q == LIMIT);
`else
        assign promote = 1'b0;
`endif

        assign lvl_d[i*LVL_W +: LVL_W] = promote ? TOP_LVL : raw_lvl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            req_q   <= '0;
            lvl_q   <= '0;
        end else if (o_ready) begin
            valid_q <= i_valid;
            if (load) begin
                req_q <= req_d;
                lvl_q <= lvl_d;
            end
        end
    end

    assign o_valid   = valid_q;
    assign o_request = req_q;
    assign o_level   = lvl_q;
    assign o_any     = |req_q;

endmodule

// File: tb/tb_fpf_request_stage.sv
// Directed bench for fpf_request_stage at N=4, P=4, AGE_LIMIT=3.
module tb_fpf_request_stage;

    localparam int N  = 4;
    localparam int P  = 4;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [N*P-1:0] i_priority = '0;
    logic [N*P-1:0] i_p_r = '0;
    logic          i_grant_valid = 1'b0;
    logic [N-1:0]  i_grant = '0;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic [N-1:0]  o_request;
    logic [N*LW-1:0] o_level;
    logic          o_any;

    int tests = 0;
    int fails = 0;

    fpf_request_stage #(
        .N         (N),
        .P         (P),
        .AGE_W     (4),
        .AGE_LIMIT (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_priority    (i_priority),
        .i_p_r         (i_p_r),
        .i_grant_valid (i_grant_valid),
        .i_grant       (i_grant),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_request     (o_request),
        .o_level       (o_level),
        .o_any         (o_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [3:0] r, input logic [7:0] l);
        chk({tag, "_valid"}, 32'(o_valid), 32'(v));
        chk({tag, "_req"}, 32'(o_request), 32'(r));
        chk({tag, "_lvl"}, 32'(o_level), 32'(l));
        chk({tag, "_any"}, 32'(o_any), 32'(|r));
    endtask

    initial begin
        step();
        step();
        chk_out("reset", 1'b0, 4'h0, 8'h00);
        chk("reset_ready", 32'(o_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // req0 lvl0, req1 lvls0-3, all permitted
        i_priority = 16'h00F1;
        i_p_r      = 16'hFFFF;
        i_valid    = 1'b1;
        step();
        chk_out("basic", 1'b1, 4'b0011, 8'h0C);

        // only level 1 permitted, for req1
        i_p_r = 16'h0020;
        step();
        chk_out("permit", 1'b1, 4'b0010, 8'h04);

        // one level per requester, all permitted
        i_priority = 16'h8421;
        i_p_r      = 16'hFFFF;
        step();
        chk_out("diag", 1'b1, 4'b1111, 8'hE4);

        // backpressure: outputs hold while new data toggles
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_valid    = k[0] ? 1'b0 : 1'b1;
            i_priority = 16'hF000;
            step();
            chk_out("hold", 1'b1, 4'b1111, 8'hE4);
            chk("hold_ready", 32'(o_ready), 32'd0);
        end
        i_ready    = 1'b1;
        i_valid    = 1'b1;
        i_priority = 16'h0600;
        i_p_r      = 16'h0040;
        step();
        chk_out("release", 1'b1, 4'b0100, 8'h10);

        i_valid = 1'b0;
        step();
        chk("drain_valid", 32'(o_valid), 32'd0);
        chk("drain_ready", 32'(o_ready), 32'd1);

        // async reset while a beat is held
        i_valid    = 1'b1;
        i_priority = 16'h8421;
        i_p_r      = 16'hFFFF;
        step();
        i_valid = 1'b0;
        i_ready = 1'b0;
        chk("pre_rst_valid", 32'(o_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 4'h0, 8'h00);
        @(negedge clk);
        rst_n   = 1'b1;
        i_ready = 1'b1;
        step();

        // req2 at level 0 each beat; starve 3 feedbacks then grant once
        for (int k = 0; k < 5; k++) begin
            logic [7:0] exp_l;
            exp_l = 8'h00;
`ifdef FPF_AGING_EN
            if (k == 3) exp_l = 8'h30;
`endif
            i_priority = 16'h0100;
            i_p_r      = 16'hFFFF;
            i_valid    = 1'b1;
            step();
            i_valid = 1'b0;
            chk_out($sformatf("age%0d", k), 1'b1, 4'b0100, exp_l);
            step();
            i_grant_valid = 1'b1;
            i_grant       = (k == 3) ? 4'b0100 : 4'b0000;
            step();
            i_grant_valid = 1'b0;
            i_grant       = '0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
